// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - single-outstanding load/store master for a single-cycle RAM data port
// Optional feature macro: LSU_PERF_EN adds perf_ld_cnt / perf_st_cnt access counters.
module lsu_mem_master #(
    parameter int          XLEN     = 64,
    parameter logic [63:0] PC_START = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic            resp_fault,
    output logic            mem_rd_ena,
    output logic            mem_wr_ena,
    output logic [7:0]      byte_enable,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wr_data,
    input  logic [XLEN-1:0] mem_rd_data
`ifdef LSU_PERF_EN
    ,
    output logic [31:0]     perf_ld_cnt,
    output logic [31:0]     perf_st_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_wen;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              r_misalign;
    logic              r_fault;

    logic              w_req_misalign;
    logic              w_req_fault;
    logic              w_access;
    logic [7:0]        w_size_mask;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load_ext;

    always_comb begin
        w_req_misalign = 1'b0;
        case (req_size)
            2'd1:    w_req_misalign = req_addr[0];
            2'd2:    w_req_misalign = |req_addr[1:0];
            2'd3:    w_req_misalign = |req_addr[2:0];
            default: w_req_misalign = 1'b0;
        endcase
    end

    assign w_req_fault = (req_addr < PC_START);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = (w_req_misalign || w_req_fault) ? S_RESP : S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Gating with rst_n makes the RAM enables drop the instant reset asserts,
    // so a store caught in ACCESS is never committed on the following edge.
    assign w_access  = rst_n && (r_state == S_ACCESS);
    assign req_ready = rst_n && (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);

    always_comb begin
        w_size_mask = 8'h00;
        case (r_size)
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    assign mem_rd_ena  = w_access && !r_wen;
    assign mem_wr_ena  = w_access && r_wen;
    assign byte_enable = w_access ? (w_size_mask << r_addr[2:0]) : 8'h00;
    assign mem_addr    = w_access ? {r_addr[XLEN-1:3], 3'b000} : '0;
    assign mem_wr_data = w_access ? (r_wdata << {r_addr[2:0], 3'b000}) : '0;

    assign w_shifted = mem_rd_data >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_load_ext = '0;
        case (r_size)
            2'd0:    w_load_ext = {{56{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load_ext = {{48{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load_ext = {{32{r_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wen      <= 1'b0;
            r_size     <= 2'd0;
            r_signed   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_wen      <= req_wen;
                r_size     <= req_size;
                r_signed   <= req_signed;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rdata    <= '0;
                r_misalign <= w_req_misalign;
                r_fault    <= w_req_fault;
            end
            if (r_state == S_ACCESS && !r_wen) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign resp_rdata    = r_rdata;
    assign resp_misalign = r_misalign;
    assign resp_fault    = r_fault;

`ifdef LSU_PERF_EN
    logic [31:0] r_perf_ld_cnt;
    logic [31:0] r_perf_st_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ld_cnt <= 32'd0;
            r_perf_st_cnt <= 32'd0;
        end else if (r_state == S_ACCESS) begin
            if (r_wen) r_perf_st_cnt <= r_perf_st_cnt + 32'd1;
            else       r_perf_ld_cnt <= r_perf_ld_cnt + 32'd1;
        end
    end

    assign perf_ld_cnt = r_perf_ld_cnt;
    assign perf_st_cnt = r_perf_st_cnt;
`endif

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store requester on the CPU side of the single-cycle RAM data port: drives mem_rd_ena / mem_wr_ena / byte_enable / mem_addr / mem_wr_data and consumes mem_rd_data.
- Accepts one load or store from the EX/MEM stage over a valid/ready handshake and aligns store data into byte lanes.
- Extracts and extends load data, flags misaligned accesses, and returns a registered response.
- Sits between the execute stage and the RAM data port; at most one transaction outstanding.

Parameters:
- XLEN, 64, address/data width; only 64 is supported.
- PC_START, 64'h8000_0000, lowest legal data address; addresses below it are flagged as an access fault.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_signed  in  1  load sign-extends when 1, zero-extends when 0
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  64  extended load data; 0 for stores and faults
- resp_misalign  out  1  address not a multiple of the access size
- resp_fault  out  1  address below PC_START
- mem_rd_ena  out  1  RAM read enable
- mem_wr_ena  out  1  RAM write enable
- byte_enable  out  8  RAM byte lane mask
- mem_addr  out  64  RAM address, {addr[63:3], 3'b000}
- mem_wr_data  out  64  lane-aligned store data
- mem_rd_data  in  64  RAM read data, combinational from mem_addr

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n = 0:
  - state = IDLE.
  - All outputs, including req_ready, are 0.
  - All internal registers are cleared.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at an edge, the block latches wen/size/signed/addr/wdata.
  - If misaligned or faulted, next state is RESP and the RAM enables are never asserted. Otherwise next state is ACCESS.
- ACCESS (exactly one cycle):
  - mem_rd_ena = ~wen, mem_wr_ena = wen.
  - mem_addr = {addr[63:3], 3'b000}.
  - byte_enable = (size mask 8'h01/8'h03/8'h0F/8'hFF) << addr[2:0].
  - mem_wr_data = wdata << (8*addr[2:0]).
  - The RAM commits the store on the closing edge.
  - For loads, mem_rd_data is sampled on the closing edge, shifted right by 8*addr[2:0], truncated to size, and sign- or zero-extended into resp_rdata.
  - Next state is RESP.
- RESP:
  - resp_valid = 1; resp_rdata, resp_misalign and resp_fault are stable.
  - On resp_ready the block returns to IDLE.
  - req_ready = 0, so there is no accept-while-responding.
- Outside ACCESS: mem_rd_ena, mem_wr_ena, byte_enable, mem_addr and mem_wr_data are all 0.
- Latency: accept at edge N; ACCESS occupies cycle N+1; resp_valid is asserted from cycle N+2. Minimum throughput is one transaction per 3 cycles.
- Misalign rule:
  - Half: addr[0] ≠ 0.
  - Word: addr[1:0] ≠ 0.
  - Double: addr[2:0] ≠ 0.
  - Byte: never misaligned.
- Fault rule: addr < PC_START. When both apply, both flags are set.
- Stores respond with resp_rdata = 0.
- req_* inputs are ignored outside IDLE.
- Reset asserted mid-transaction: abandons immediately. A store in ACCESS is not committed if rst_n falls before the edge, because the enables are forced to 0.

Optional Feature:
- Macro: LSU_PERF_EN.
- Defined:
  - Adds outputs perf_ld_cnt[31:0] and perf_st_cnt[31:0].
  - Each increments by 1 on the ACCESS cycle of a load or store respectively; faulted and misaligned requests are not counted.
  - Counters wrap 32'hFFFF_FFFF -> 0 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store double 64'h1122_3344_5566_7788 at 0x8000_0010 -> ACCESS cycle: byte_enable = 8'hFF, mem_addr = 0x8000_0010, mem_wr_data = 64'h1122_3344_5566_7788; resp_valid at N+2, resp_rdata = 0.
- Store byte 0xAB at 0x8000_0013 -> byte_enable = 8'h08, mem_wr_data[31:24] = 8'hAB; a following signed byte load from the same address, with RAM word 64'h0000_0000_AB00_0000, gives resp_rdata = 64'hFFFF_FFFF_FFFF_FFAB; an unsigned byte load gives 64'h0000_0000_0000_00AB.
- Signed word load at 0x8000_0004, RAM word 64'h8000_0001_0000_0000 -> byte_enable = 8'hF0, resp_rdata = 64'hFFFF_FFFF_8000_0001.
- Half load at 0x8000_0001 -> no mem_rd_ena pulse, resp_misalign = 1, resp_rdata = 0, resp_valid at N+1. Byte load at 0x7FFF_FFFF -> resp_fault = 1, resp_misalign = 0.
- Hold resp_ready = 0 for 5 cycles -> resp_valid and data stay stable, req_ready = 0. Drop rst_n during ACCESS of a store -> mem_wr_ena goes to 0 immediately and state returns to IDLE after reset.
- With LSU_PERF_EN: 3 loads, 2 stores and 1 misaligned load -> perf_ld_cnt = 3, perf_st_cnt = 2. Force the counter to 32'hFFFF_FFFF, perform 1 load -> counter reads 0.
